// File: rtl/serial_word_tx.sv
// Parallel-in serial-out word transmitter with MSB-first or LSB-first bit order.
// Latency: first bit one cycle after accept, WIDTH bit cycles, then a done pulse on the next cycle.
// Backpressure: load_ready is low for the whole frame; hold freezes the shifter with sout_valid low.
module serial_word_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             left,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dir_q, dir_nxt;
    logic             sout_nxt, sout_valid_nxt, frame_start_nxt, done_nxt;
    logic             accept;

    assign load_ready = (state == IDLE);
    assign accept     = load_valid && load_ready;

    // State and registered datapath/outputs; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            dir_q       <= 1'b0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            cnt         <= cnt_nxt;
            dir_q       <= dir_nxt;
            sout        <= sout_nxt;
            sout_valid  <= sout_valid_nxt;
            frame_start <= frame_start_nxt;
            done        <= done_nxt;
        end
    end

    // Next state: leave IDLE on accept, return once the last bit has been presented
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (!hold && cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next datapath and output values; the bit on deck is always the neighbour of the
    // edge bit just sent, since shreg shifts toward the outgoing end each bit
    always_comb begin
        shreg_nxt       = shreg;
        cnt_nxt         = cnt;
        dir_nxt         = dir_q;
        sout_nxt        = 1'b0;
        sout_valid_nxt  = 1'b0;
        frame_start_nxt = 1'b0;
        done_nxt        = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nxt       = data_in;
                    dir_nxt         = left;
                    sout_nxt        = left ? data_in[WIDTH-1] : data_in[0];
                    sout_valid_nxt  = 1'b1;
                    frame_start_nxt = 1'b1;
                    cnt_nxt         = CNT_LAST;
                end
            end
            SHIFT: begin
                if (hold) begin
                    sout_nxt = sout;
                end else if (cnt != '0) begin
                    if (dir_q) begin
                        sout_nxt  = shreg[WIDTH-2];
                        shreg_nxt = shreg << 1;
                    end else begin
                        sout_nxt  = shreg[1];
                        shreg_nxt = shreg >> 1;
                    end
                    sout_valid_nxt = 1'b1;
                    cnt_nxt        = cnt - CNT_ONE;
                end else begin
                    done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_word_tx.sv
module tb_serial_word_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data_in = 4'h0;
    logic       left = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic       hold = 1'b0;
    logic       sout;
    logic       sout_valid;
    logic       frame_start;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    serial_word_tx #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .left        (left),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .hold        (hold),
        .sout        (sout),
        .sout_valid  (sout_valid),
        .frame_start (frame_start),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       lv;
        logic [3:0] din;
        logic       left;
        logic       hold;
        logic       sout;
        logic       sv;
        logic       fs;
        logic       dn;
        logic       rdy;
    } vec_t;

    localparam int NV = 32;
    vec_t tv [NV];

    function automatic vec_t mk(input logic r, input logic lv, input logic [3:0] d,
                                input logic l, input logic h, input logic so,
                                input logic sv, input logic fs, input logic dn,
                                input logic rdy);
        vec_t v;
        v.rst = r; v.lv = lv; v.din = d; v.left = l; v.hold = h;
        v.sout = so; v.sv = sv; v.fs = fs; v.dn = dn; v.rdy = rdy;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Accept one word, then act as the downstream shift register until done
    task automatic send_word(input string nm, input logic [3:0] w, input logic l,
                             input logic [3:0] exp_seq);
        logic [3:0] seq;
        logic [3:0] q;
        int         nb;
        int         nfs;
        bit         got_done;
        seq = 4'h0; q = 4'h0; nb = 0; nfs = 0; got_done = 0;
        rst = 1'b0; hold = 1'b0; data_in = w; left = l; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < 12 && !got_done; c++) begin
            if (sout_valid) begin
                seq = {seq[2:0], sout};
                if (l) q = {q[2:0], sout};
                else   q = {sout, q[3:1]};
                if (frame_start) nfs++;
                nb++;
            end
            if (done) got_done = 1;
            else tick();
        end
        chk({nm, " done_seen"}, 32'(got_done), 32'd1);
        chk({nm, " bit_count"}, 32'(nb), 32'd4);
        chk({nm, " frame_start_count"}, 32'(nfs), 32'd1);
        chk({nm, " bit_order"}, 32'(seq), 32'(exp_seq));
        chk({nm, " rx_q"}, 32'(q), 32'(w));
    endtask

    initial begin
        // Reset with a pending word, then MSB/LSB frames, hold, mid-frame interference
        //              rst lv  din    l  h   sout sv fs dn rdy
        tv[0]  = mk(1, 1, 4'hF, 1, 0,  0, 0, 0, 0, 1);
        tv[1]  = mk(1, 1, 4'hF, 1, 0,  0, 0, 0, 0, 1);
        tv[2]  = mk(0, 0, 4'hF, 1, 0,  0, 0, 0, 0, 1);
        tv[3]  = mk(0, 1, 4'hB, 1, 0,  1, 1, 1, 0, 0);
        tv[4]  = mk(0, 0, 4'hB, 1, 0,  0, 1, 0, 0, 0);
        tv[5]  = mk(0, 0, 4'hB, 1, 0,  1, 1, 0, 0, 0);
        tv[6]  = mk(0, 0, 4'hB, 1, 0,  1, 1, 0, 0, 0);
        tv[7]  = mk(0, 0, 4'hB, 1, 0,  0, 0, 0, 1, 1);
        tv[8]  = mk(0, 1, 4'hB, 0, 0,  1, 1, 1, 0, 0);
        tv[9]  = mk(0, 0, 4'hB, 0, 0,  1, 1, 0, 0, 0);
        tv[10] = mk(0, 0, 4'hB, 0, 0,  0, 1, 0, 0, 0);
        tv[11] = mk(0, 0, 4'hB, 0, 0,  1, 1, 0, 0, 0);
        tv[12] = mk(0, 0, 4'hB, 0, 0,  0, 0, 0, 1, 1);
        tv[13] = mk(0, 1, 4'h6, 1, 0,  0, 1, 1, 0, 0);
        tv[14] = mk(0, 0, 4'h6, 1, 0,  1, 1, 0, 0, 0);
        tv[15] = mk(0, 0, 4'h6, 1, 1,  1, 0, 0, 0, 0);
        tv[16] = mk(0, 0, 4'h6, 1, 1,  1, 0, 0, 0, 0);
        tv[17] = mk(0, 0, 4'h6, 1, 1,  1, 0, 0, 0, 0);
        tv[18] = mk(0, 0, 4'h6, 1, 0,  1, 1, 0, 0, 0);
        tv[19] = mk(0, 0, 4'h6, 1, 0,  0, 1, 0, 0, 0);
        tv[20] = mk(0, 0, 4'h6, 1, 0,  0, 0, 0, 1, 1);
        tv[21] = mk(0, 1, 4'hB, 1, 0,  1, 1, 1, 0, 0);
        tv[22] = mk(0, 1, 4'hF, 0, 0,  0, 1, 0, 0, 0);
        tv[23] = mk(0, 1, 4'hF, 1, 0,  1, 1, 0, 0, 0);
        tv[24] = mk(0, 1, 4'hF, 0, 0,  1, 1, 0, 0, 0);
        tv[25] = mk(0, 1, 4'hF, 0, 1,  1, 0, 0, 0, 0);
        tv[26] = mk(0, 1, 4'hF, 0, 0,  0, 0, 0, 1, 1);
        tv[27] = mk(0, 1, 4'hF, 1, 1,  1, 1, 1, 0, 0);
        tv[28] = mk(0, 0, 4'h0, 0, 0,  1, 1, 0, 0, 0);
        tv[29] = mk(0, 0, 4'h0, 0, 0,  1, 1, 0, 0, 0);
        tv[30] = mk(0, 0, 4'h0, 0, 0,  1, 1, 0, 0, 0);
        tv[31] = mk(0, 0, 4'h0, 0, 0,  0, 0, 0, 1, 1);

        for (int i = 0; i < NV; i++) begin
            rst = tv[i].rst; load_valid = tv[i].lv; data_in = tv[i].din;
            left = tv[i].left; hold = tv[i].hold;
            tick();
            chk($sformatf("v%0d sout", i),        32'(sout),        32'(tv[i].sout));
            chk($sformatf("v%0d sout_valid", i),  32'(sout_valid),  32'(tv[i].sv));
            chk($sformatf("v%0d frame_start", i), 32'(frame_start), 32'(tv[i].fs));
            chk($sformatf("v%0d done", i),        32'(done),        32'(tv[i].dn));
            chk($sformatf("v%0d load_ready", i),  32'(load_ready),  32'(tv[i].rdy));
        end

        // Receiver loopback, both directions
        send_word("msb_1011", 4'b1011, 1'b1, 4'b1011);
        send_word("lsb_1011", 4'b1011, 1'b0, 4'b1101);

        // Reset after the second bit of 1100 aborts the frame without a done pulse
        rst = 1'b0; hold = 1'b0; data_in = 4'b1100; left = 1'b1; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("abort bit1", 32'(sout), 32'd1);
        tick();
        chk("abort bit2", 32'(sout), 32'd1);
        chk("abort bit2_valid", 32'(sout_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort sout_valid", 32'(sout_valid), 32'd0);
        chk("abort sout", 32'(sout), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort load_ready", 32'(load_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("abort idle%0d done", c), 32'(done), 32'd0);
            chk($sformatf("abort idle%0d sout_valid", c), 32'(sout_valid), 32'd0);
        end
        send_word("after_abort_0011", 4'b0011, 1'b1, 4'b0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
